// File: rtl/stopwatch_ctrl_if.sv
// Button-pulse and display bus between the stopwatch front panel and
// stopwatch_ctrl. The master side drives the debounced pulses and the lap
// selector; the slave side (the controller) drives the tick count and the
// status flags.
interface stopwatch_ctrl_if;
  logic        start_stop;
  logic        lap;
  logic        clear;
  logic [1:0]  lap_sel;
  logic [38:0] time_out;
  logic        running;
  logic        lap_view;
  logic [2:0]  lap_count;
  logic        overflow;

  modport master (
    output start_stop, lap, clear, lap_sel,
    input  time_out, running, lap_view, lap_count, overflow
  );

  modport slave (
    input  start_stop, lap, clear, lap_sel,
    output time_out, running, lap_view, lap_count, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: run/pause/lap/clear FSM, tick prescaler,
// millisecond counter with saturation, and lap capture. Drives a registered
// 39-bit tick count to the time-to-BCD converter.
// Optional feature macro: LAP_BUFFER_EN (4-entry lap store selected by
// lap_sel). Without it a single lap register is kept and lap_sel is unused.
module stopwatch_ctrl #(
  parameter int unsigned TICKS_PER_MS = 100000,
  parameter int unsigned MAX_MS       = 5400000
) (
  input  logic            clk,
  input  logic            rst,
  stopwatch_ctrl_if.slave bus
);

  localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int MW = $clog2(MAX_MS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_MS - 1);
  localparam logic [MW-1:0] MS_LAST   = MW'(MAX_MS - 1);

  typedef enum logic [2:0] {IDLE, RUN, LAP, PAUSE, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] tick_cnt;
  logic [MW-1:0] ms_cnt;
  logic [38:0]   live;
  logic [38:0]   lap_shown;
  logic [2:0]    lap_count;
  logic          counting;
  logic          sat_hit;
  logic          count_en;
  logic          capture;
  logic          zero_all;

  // Counting happens only in RUN and LAP; saturation is the increment that
  // would carry ms_cnt onto MAX_MS.
  assign counting = (state == RUN) || (state == LAP);
  assign sat_hit  = counting && (tick_cnt == TICK_LAST) && (ms_cnt == MS_LAST);
  assign live     = 39'(ms_cnt) * 39'(TICKS_PER_MS) + 39'(tick_cnt);

  // Next state: saturation wins, then clear > start_stop > lap among the
  // pulses that are legal in the current state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can leave one unassigned and infer a latch.
    state_next = state;
    capture    = 1'b0;
    zero_all   = 1'b0;
    case (state)
      IDLE: if (bus.start_stop) state_next = RUN;
      RUN: begin
        if (sat_hit)             state_next = DONE;
        else if (bus.start_stop) state_next = PAUSE;
        else if (bus.lap) begin
          state_next = LAP;
          capture    = 1'b1;
        end
      end
      LAP: begin
        if (sat_hit)             state_next = DONE;
        else if (bus.start_stop) state_next = PAUSE;
        else if (bus.lap)        state_next = RUN;
      end
      PAUSE: begin
        if (bus.clear) begin
          state_next = IDLE;
          zero_all   = 1'b1;
        end else if (bus.start_stop) begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (bus.clear) begin
          state_next = IDLE;
          zero_all   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A pause takes effect on its own edge, so the edge that leaves for PAUSE
  // does not count; that keeps sub-ms progress exact across pauses.
  assign count_en = counting && (state_next != PAUSE);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Prescaler and millisecond counter; saturation lands on ms_cnt=MAX_MS, tick_cnt=0
  always_ff @(posedge clk) begin
    if (rst || zero_all) begin
      tick_cnt <= '0;
      ms_cnt   <= '0;
    end else if (count_en) begin
      if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
        ms_cnt   <= ms_cnt + MW'(1);
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end

`ifdef LAP_BUFFER_EN
  logic [38:0] laps [4];
  logic [1:0]  newest;

  assign newest    = 2'(lap_count - 3'd1);
  assign lap_shown = ({1'b0, bus.lap_sel} < lap_count) ? laps[bus.lap_sel] : laps[newest];

  // Lap store: append captures until four entries are held, then keep them
  always_ff @(posedge clk) begin
    if (rst || zero_all) begin
      // NOTE: entries are zeroed on clear/rst, not merely hidden behind lap_count, so no old lap can ever reach time_out.
      for (int i = 0; i < 4; i++) laps[i] <= '0;
      lap_count <= '0;
    end else if (capture && (lap_count != 3'd4)) begin
      laps[lap_count[1:0]] <= live;
      lap_count            <= lap_count + 3'd1;
    end
  end
`else
  logic [38:0] lap_reg;
  logic        unused_lap_sel;

  assign unused_lap_sel = ^bus.lap_sel;
  assign lap_shown      = lap_reg;

  // Single lap register, overwritten by every capture
  always_ff @(posedge clk) begin
    if (rst || zero_all) begin
      lap_reg   <= '0;
      lap_count <= '0;
    end else if (capture) begin
      lap_reg   <= live;
      lap_count <= 3'd1;
    end
  end
`endif

  assign bus.lap_count = lap_count;

  // Registered outputs: flags decode the new state, time_out trails the counters by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.time_out <= '0;
      bus.running  <= 1'b0;
      bus.lap_view <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.time_out <= (state == LAP) ? lap_shown : live;
      bus.running  <= (state_next == RUN) || (state_next == LAP);
      bus.lap_view <= (state_next == LAP);
      bus.overflow <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (TICKS_PER_MS=10, MAX_MS=20).
// A reference model tracks the live value as one integer and the laps as a
// queue; it is compared against the DUT every cycle. On top of that a table
// of hand-derived vectors and a few lap-store sequences check fixed values.
module tb_stopwatch_ctrl;

  localparam int TPM   = 10;
  localparam int MAXMS = 20;
  localparam int SAT   = TPM * MAXMS;
`ifdef LAP_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stopwatch_ctrl_if bus();

  stopwatch_ctrl #(.TICKS_PER_MS(TPM), .MAX_MS(MAXMS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_RUN, M_LAP, M_PAUSE, M_DONE} mode_t;
  mode_t       m_mode = M_IDLE;
  int          m_live = 0;
  int          m_laps[$];
  int          m_lap_single = 0;
  bit          m_single_valid = 1'b0;
  logic [44:0] m_out = '0;   // {time_out, running, lap_view, lap_count, overflow}
  logic [44:0] m_mask = '1;

  function automatic int lap_total();
    if (BUF) return m_laps.size();
    return m_single_valid ? 1 : 0;
  endfunction

  function automatic int shown(input logic [1:0] sel);
    if (BUF) begin
      if (m_laps.size() == 0) return 0;
      if (int'(sel) < m_laps.size()) return m_laps[sel];
      return m_laps[m_laps.size() - 1];
    end
    return m_lap_single;
  endfunction

  task automatic model_step(input bit r, input bit ss, input bit lp, input bit clr,
                            input logic [1:0] sel);
    int    t_next;
    mode_t nm;
    bit    counting, sat, do_clr, do_ss, do_lap;
    t_next = (m_mode == M_LAP) ? shown(sel) : m_live;
    if (r) begin
      m_mode = M_IDLE;
      m_live = 0;
      m_laps.delete();
      m_lap_single   = 0;
      m_single_valid = 1'b0;
      m_out  = '0;
      m_mask = 45'h3F;   // time_out is only required to be 0 a cycle later
    end else begin
      counting = (m_mode == M_RUN) || (m_mode == M_LAP);
      sat      = counting && (m_live + 1 == SAT);
      do_clr   = clr && (m_mode == M_PAUSE || m_mode == M_DONE);
      do_ss    = ss && (m_mode != M_DONE);
      do_lap   = lp && counting;
      nm = m_mode;
      if (sat) nm = M_DONE;
      else if (do_clr) nm = M_IDLE;
      else if (do_ss) nm = (m_mode == M_IDLE || m_mode == M_PAUSE) ? M_RUN : M_PAUSE;
      else if (do_lap) begin
        if (m_mode == M_RUN) begin
          nm = M_LAP;
          if (BUF) begin
            if (m_laps.size() < 4) m_laps.push_back(m_live);
          end else begin
            m_lap_single   = m_live;
            m_single_valid = 1'b1;
          end
        end else begin
          nm = M_RUN;
        end
      end
      if (counting && nm != M_PAUSE) m_live++;
      if (!sat && do_clr) begin
        m_live = 0;
        m_laps.delete();
        m_lap_single   = 0;
        m_single_valid = 1'b0;
      end
      m_mode = nm;
      m_out  = {39'(t_next), (nm == M_RUN || nm == M_LAP), (nm == M_LAP),
                3'(lap_total()), (nm == M_DONE)};
      m_mask = '1;
    end
  endtask

  // ---------------- helpers ----------------
  function automatic logic [44:0] dut_out();
    return {bus.time_out, bus.running, bus.lap_view, bus.lap_count, bus.overflow};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock: drive pulses, advance the model, sample #1 after the edge.
  task automatic cycle(input bit ss, input bit lp, input bit clr, input logic [1:0] sel);
    bus.start_stop = ss;
    bus.lap        = lp;
    bus.clear      = clr;
    bus.lap_sel    = sel;
    model_step(rst, ss, lp, clr, sel);
    @(posedge clk);
    #1;
    check("model", 64'(dut_out() & m_mask), 64'(m_out & m_mask));
    bus.start_stop = 1'b0;
    bus.lap        = 1'b0;
    bus.clear      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 250 && m_live < target; k++) cycle(1'b0, 1'b0, 1'b0, 2'd0);
    if (m_live != target) begin
      $display("FAIL run_to: live %0d required %0d", m_live, target);
      $fatal(1, "sequence lost alignment");
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit ss;
    bit lp;
    bit clr;
    int wait_n;
    int t;
    bit run;
    bit lv;
    bit ov;
    int lc;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int targets[5];
    int seg_density;

    //             ss   lp   clr  wait  time run lv  ov  lc
    tbl[0]  = '{1'b1, 1'b0, 1'b0,  36,  35, 1'b1, 1'b0, 1'b0, 0};  // 35 ticks counted
    tbl[1]  = '{1'b1, 1'b0, 1'b0,  50,  36, 1'b0, 1'b0, 1'b0, 0};  // pause holds
    tbl[2]  = '{1'b1, 1'b0, 1'b0,   5,  40, 1'b1, 1'b0, 1'b0, 0};  // no sub-ms loss
    tbl[3]  = '{1'b0, 1'b0, 1'b0,  15,  56, 1'b1, 1'b0, 1'b0, 0};  // live now 57
    tbl[4]  = '{1'b0, 1'b1, 1'b0,   1,  57, 1'b1, 1'b1, 1'b0, 1};  // lap captures 57
    tbl[5]  = '{1'b0, 1'b0, 1'b0,  28,  57, 1'b1, 1'b1, 1'b0, 1};  // view holds
    tbl[6]  = '{1'b0, 1'b1, 1'b0,   1,  89, 1'b1, 1'b0, 1'b0, 1};  // release to live
    tbl[7]  = '{1'b0, 1'b0, 1'b1,   1,  91, 1'b1, 1'b0, 1'b0, 1};  // clear in RUN ignored
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 107, 199, 1'b0, 1'b0, 1'b1, 1};  // saturate
    tbl[9]  = '{1'b1, 1'b0, 1'b0,   0, 200, 1'b0, 1'b0, 1'b1, 1};  // ss ignored in DONE
    tbl[10] = '{1'b0, 1'b1, 1'b0,   2, 200, 1'b0, 1'b0, 1'b1, 1};  // lap ignored in DONE
    tbl[11] = '{1'b0, 1'b0, 1'b1,   0, 200, 1'b0, 1'b0, 1'b0, 0};  // clear -> IDLE
    tbl[12] = '{1'b0, 1'b0, 1'b0,   0,   0, 1'b0, 1'b0, 1'b0, 0};  // time_out zero
    tbl[13] = '{1'b1, 1'b0, 1'b0,   4,   3, 1'b1, 1'b0, 1'b0, 0};
    tbl[14] = '{1'b1, 1'b0, 1'b0,   0,   4, 1'b0, 1'b0, 1'b0, 0};  // pause at 4
    tbl[15] = '{1'b1, 1'b0, 1'b1,   1,   0, 1'b0, 1'b0, 1'b0, 0};  // clear beats ss
    tbl[16] = '{1'b0, 1'b1, 1'b0,   2,   0, 1'b0, 1'b0, 1'b0, 0};  // lap ignored in IDLE
    tbl[17] = '{1'b0, 1'b0, 1'b1,   0,   0, 1'b0, 1'b0, 1'b0, 0};  // clear in IDLE

    bus.start_stop = 1'b0;
    bus.lap        = 1'b0;
    bus.clear      = 1'b0;
    bus.lap_sel    = 2'd0;
    rst            = 1'b1;

    do_reset();
    check("reset_state", 64'({bus.running, bus.lap_view, bus.lap_count, bus.overflow}), 64'(0));
    cycle(1'b0, 1'b0, 1'b0, 2'd0);
    check("reset_time", 64'(bus.time_out), 64'(0));

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].ss, tbl[i].lp, tbl[i].clr, 2'd0);
      for (int w = 0; w < tbl[i].wait_n; w++) cycle(1'b0, 1'b0, 1'b0, 2'd0);
      check($sformatf("row%0d", i),
            64'({bus.time_out, bus.running, bus.lap_view, bus.overflow, bus.lap_count}),
            64'({39'(tbl[i].t), tbl[i].run, tbl[i].lv, tbl[i].ov, 3'(tbl[i].lc)}));
    end

    // rst asserted mid-count
    cycle(1'b1, 1'b0, 1'b0, 2'd0);
    for (int w = 0; w < 20; w++) cycle(1'b0, 1'b0, 1'b0, 2'd0);
    do_reset();
    check("rst_mid_flags", 64'({bus.running, bus.lap_view, bus.lap_count, bus.overflow}), 64'(0));
    cycle(1'b0, 1'b0, 1'b0, 2'd0);
    check("rst_mid_time", 64'(bus.time_out), 64'(0));

    // Five captures at live 12/34/56/78/90
    targets = '{12, 34, 56, 78, 90};
    cycle(1'b1, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      run_to(targets[i]);
      cycle(1'b0, 1'b1, 1'b0, 2'd0);
      cycle(1'b0, 1'b0, 1'b0, 2'd0);
      check($sformatf("cap%0d_count", i), 64'({bus.lap_view, bus.lap_count}),
            64'({1'b1, BUF ? 3'((i < 4) ? i + 1 : 4) : 3'd1}));
      if (BUF) begin
        if (i == 1) begin
          cycle(1'b0, 1'b0, 1'b0, 2'd3);
          check("sel3_beyond_count", 64'(bus.time_out), 64'(34));
        end
        if (i >= 3) begin
          cycle(1'b0, 1'b0, 1'b0, 2'd1);
          check($sformatf("cap%0d_sel1", i), 64'(bus.time_out), 64'(34));
          cycle(1'b0, 1'b0, 1'b0, 2'd3);
          check($sformatf("cap%0d_sel3", i), 64'(bus.time_out), 64'(78));
        end
      end else begin
        cycle(1'b0, 1'b0, 1'b0, 2'd3);
        check($sformatf("cap%0d_single", i), 64'(bus.time_out), 64'(targets[i]));
      end
      cycle(1'b0, 1'b1, 1'b0, 2'd0);
    end

    // Randomized phase: alternate dense and sparse pulse segments so that
    // saturation is reached in the sparse ones.
    do_reset();
    for (int seg = 0; seg < 8; seg++) begin
      seg_density = (seg % 2 == 0) ? 12 : 400;
      for (int c = 0; c < 500; c++) begin
        rst = ($urandom_range(0, 799) == 0);
        cycle($urandom_range(0, seg_density - 1) == 0,
              $urandom_range(0, seg_density / 2) == 0,
              $urandom_range(0, seg_density - 1) == 0,
              2'($urandom_range(0, 3)));
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the stopwatch datapath. It owns the run/pause/lap/clear state machine, the free-running tick prescaler and millisecond counter, and lap capture. It drives a registered 39-bit tick count (10 ns units at 100 MHz) into the time-to-BCD converter that feeds the mm:ss.mmm display. Button inputs are already debounced single-cycle pulses.

## Interface
- TICKS_PER_MS, default 100000: clock ticks per millisecond.
- MAX_MS, default 5400000: saturation point in ms (90 min). MAX_MS*TICKS_PER_MS must fit in 39 bits.
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, synchronous, active-high.
- start_stop  in  1  single-cycle pulse, toggles run/pause.
- lap  in  1  single-cycle pulse, capture lap or release lap view.
- clear  in  1  single-cycle pulse, zero the stopwatch (honoured only when paused or done).
- lap_sel  in  2  lap entry to display in LAP state (LAP_BUFFER_EN only).
- time_out  out  39  tick count to the converter.
- running  out  1  high in RUN and LAP.
- lap_view  out  1  high in LAP.
- lap_count  out  3  number of stored laps.
- overflow  out  1  high in DONE.

## Operation
- States: IDLE, RUN, LAP, PAUSE, DONE. Reset or `rst` goes to IDLE, where every output is 0.
- Prescaler `tick_cnt` counts 0..TICKS_PER_MS-1 in RUN and LAP. At the terminal value it wraps to 0 and `ms_cnt` increments.
  - PAUSE freezes both counters without clearing them, so sub-ms progress is kept across a pause.
- Live value = ms_cnt*TICKS_PER_MS + tick_cnt.
- Transitions:
  - IDLE: start_stop goes to RUN. lap and clear are ignored.
  - RUN:
    - start_stop goes to PAUSE.
    - lap captures the live value and goes to LAP.
    - ms_cnt reaching MAX_MS goes to DONE.
  - LAP: counting continues.
    - lap goes to RUN, releasing the view.
    - start_stop goes to PAUSE, and the view shows the live value.
    - Saturation goes to DONE.
  - PAUSE: start_stop goes to RUN. clear goes to IDLE, which zeroes the counters and laps. lap is ignored.
  - DONE: clear goes to IDLE. All other inputs are ignored. Counters are held with ms_cnt=MAX_MS and tick_cnt=0.
- Simultaneous pulses: priority is clear > start_stop > lap. Only the highest-priority pulse that is legal in the current state acts.
- clear in RUN or LAP is ignored; the user must pause first.
- Saturation takes precedence over any pulse arriving in the same cycle.
- time_out source:
  - LAP: selected lap entry.
  - All other states: live value.

## Timing
- State, counters, and lap capture all update on the clk edge where the pulse is sampled.
- time_out is registered: it reflects state and counters 1 cycle after they update.
- The lap value captured is the live value in the cycle the lap pulse is sampled, before that cycle's increment.
- running, lap_view, overflow, and lap_count are registered and decode the new state. They are valid the cycle after the transition edge.
- rst asserted mid-count: IDLE on the next edge, and time_out=0 one cycle after that.

## Configuration
- LAP_BUFFER_EN defined:
  - 4-entry lap store. Each RUN→LAP capture writes entry lap_count, then lap_count increments.
  - Once lap_count=4, further captures still enter LAP but overwrite nothing, and lap_count stays 4.
  - In LAP, time_out shows entry lap_sel if lap_sel<lap_count. Otherwise it shows the newest entry.
- LAP_BUFFER_EN undefined:
  - Single lap register, overwritten on every capture.
  - lap_count is 0 or 1. lap_sel is ignored.
- clear→IDLE and rst empty the store in both builds.

## Test plan
All scenarios use TICKS_PER_MS=10 and MAX_MS=20.
- rst, then start_stop, then 35 cycles: ms_cnt=3, tick_cnt=5, time_out=35 (one cycle after the counters), running=1.
- RUN at ms_cnt=3, tick_cnt=5, then start_stop, 50 idle cycles, start_stop, 5 cycles: time_out=40, with no loss of sub-ms ticks.
- RUN at live 57, lap pulse: lap_view=1, time_out holds 57 while counting continues. After 30 cycles, lap pulse: RUN, time_out shows the live value ≈88.
- Run to ms_cnt=20: overflow=1, time_out=200 held. start_stop and lap are ignored. clear gives IDLE with time_out=0.
- clear in RUN has no effect. clear and start_stop in the same cycle in PAUSE gives IDLE with zeroed counters.
- With LAP_BUFFER_EN, five captures at live 12/34/56/78/90:
  - lap_count=4.
  - lap_sel=1 in LAP shows 34.
  - lap_sel=3 shows 78.
  - Entry 3 is not overwritten by 90.
